display_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for the stopwatch's 4-digit common-anode 7-segment display. It generates the 2-bit select that drives the shared 4:1 digit MUX feeding the segment decoder. It also generates the matching active-low anode enables and the decimal-point drive. A per-digit dead time keeps the anodes off while the MUX select changes, which prevents ghosting between digits.

---
 rtl/display_pkg.sv | 10 +
 rtl/display_scan_ctrl_refresh_counter.sv | 23 ++
 rtl/display_scan_ctrl.sv | 95 +++++++++
 tb/tb_display_scan_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and helpers for the 4-digit 7-segment scan controller.
package display_pkg;
    typedef enum logic [1:0] {IDLE, BLANK, SHOW} scan_state_t;

    localparam int NUM_DIGITS = 4;

    function automatic logic [NUM_DIGITS-1:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction
endpackage

// File: rtl/display_scan_ctrl_refresh_counter.sv
// Slot counter: counts 0..DIV-1 and wraps; clr has priority over counting.
module refresh_counter #(
    parameter int DIV = 50000,
    parameter int CW  = $clog2(DIV)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          wrap
);
    assign wrap = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= wrap ? '0 : cnt + CW'(1);
    end
endmodule

// File: rtl/display_scan_ctrl.sv
// Scan controller: walks sel over the four digits with a blanking gap at the
// start of each slot, driving registered active-low anode and DP enables.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD        = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [NUM_DIGITS-1:0] blank_mask,
    input  logic [NUM_DIGITS-1:0] dp_pos,
    output logic [1:0]            sel,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic                  dp_n,
    output logic                  frame_tick
);
    localparam int CW = $clog2(REFRESH_DIV);

    scan_state_t           state, state_nx;
    logic [CW-1:0]         cnt;
    logic                  wrap;
    logic                  dead_end;
    logic                  slot_end;
    logic [1:0]            sel_nx;
    logic [NUM_DIGITS-1:0] an_nx;
    logic                  dp_nx;
    logic                  tick_nx;

    // Counter is held at zero while idle so the first slot starts cleanly.
    refresh_counter #(.DIV(REFRESH_DIV), .CW(CW)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   ((state == IDLE) || !en),
        .en    (en),
        .cnt   (cnt),
        .wrap  (wrap)
    );

    assign dead_end = (DEAD > 0) && (int'(cnt) == DEAD - 1);
    assign slot_end = en && (state == SHOW) && wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (!en) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    state_nx = (DEAD == 0) ? SHOW : BLANK;
                BLANK:   if (dead_end) state_nx = SHOW;
                SHOW:    if (wrap) state_nx = (DEAD == 0) ? SHOW : BLANK;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state/sel so the registers line up
    // with the state register instead of lagging it by a cycle.
    always_comb begin
        sel_nx  = sel;
        tick_nx = 1'b0;
        an_nx   = '1;
        dp_nx   = 1'b1;
        if (slot_end) begin
            sel_nx  = sel + 2'd1;
            tick_nx = (sel == 2'd3);
        end
        if (state_nx == SHOW) begin
            an_nx = ~(onehot4(sel_nx) & ~blank_mask);
            dp_nx = ~(dp_pos[sel_nx] & ~blank_mask[sel_nx]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel        <= 2'd0;
            an_n       <= '1;
            dp_n       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            sel        <= sel_nx;
            an_n       <= an_nx;
            dp_n       <= dp_nx;
            frame_tick <= tick_nx;
        end
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: slot table, hand-written corner sequences and
// random stimulus against a slot-position reference model.
module tb_display_scan_ctrl;
    localparam int DIV_A = 8, DEAD_A = 2;
    localparam int DIV_B = 2, DEAD_B = 0;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic [3:0] blank_mask = 4'h0;
    logic [3:0] dp_pos = 4'h0;

    logic [1:0] sel_a, sel_b;
    logic [3:0] an_a, an_b;
    logic       dp_a, dp_b, tick_a, tick_b;

    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;

    always #5 clk = ~clk;

    display_scan_ctrl #(.REFRESH_DIV(DIV_A), .DEAD(DEAD_A)) dut (
        .clk(clk), .reset(reset), .en(en), .blank_mask(blank_mask), .dp_pos(dp_pos),
        .sel(sel_a), .an_n(an_a), .dp_n(dp_a), .frame_tick(tick_a));

    display_scan_ctrl #(.REFRESH_DIV(DIV_B), .DEAD(DEAD_B)) dut0 (
        .clk(clk), .reset(reset), .en(en), .blank_mask(blank_mask), .dp_pos(dp_pos),
        .sel(sel_b), .an_n(an_b), .dp_n(dp_b), .frame_tick(tick_b));

    task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] oh4(input int i);
        logic [3:0] r;
        r = 4'b0001 << (i % 4);
        return r;
    endfunction

    function automatic int div_of(input int k);
        return (k == 0) ? DIV_A : DIV_B;
    endfunction

    function automatic int dead_of(input int k);
        return (k == 0) ? DEAD_A : DEAD_B;
    endfunction

    // Reference model: position within the current slot and the digit shown.
    bit         m_act [2] = '{0, 0};
    int         m_pos [2] = '{0, 0};
    int         m_sel [2] = '{0, 0};
    bit         m_tick[2] = '{0, 0};
    logic [3:0] m_mask = 4'h0;
    logic [3:0] m_dpp  = 4'h0;

    always @(posedge clk or posedge reset) begin
        m_mask <= blank_mask;
        m_dpp  <= dp_pos;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_act[k] <= 1'b0; m_pos[k] <= 0; m_sel[k] <= 0; m_tick[k] <= 1'b0;
            end else if (!en) begin
                m_act[k] <= 1'b0; m_pos[k] <= 0; m_tick[k] <= 1'b0;
            end else if (!m_act[k]) begin
                m_act[k] <= 1'b1; m_pos[k] <= 0; m_tick[k] <= 1'b0;
            end else if (m_pos[k] + 1 == div_of(k)) begin
                m_pos[k]  <= 0;
                m_sel[k]  <= (m_sel[k] + 1) % 4;
                m_tick[k] <= (m_sel[k] == 3);
            end else begin
                m_pos[k]  <= m_pos[k] + 1;
                m_tick[k] <= 1'b0;
            end
        end
    end

    function automatic logic [3:0] exp_an(input int k);
        if (m_act[k] && m_pos[k] >= dead_of(k))
            return ~(oh4(m_sel[k]) & ~m_mask);
        return 4'hF;
    endfunction

    function automatic logic exp_dp(input int k);
        int s;
        s = m_sel[k] % 4;
        if (m_act[k] && m_pos[k] >= dead_of(k))
            return ~(m_dpp[s] & ~m_mask[s]);
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (mon_on) begin
            chk("model_sel_a",  {2'b0, sel_a},  4'(m_sel[0]));
            chk("model_an_a",   an_a,           exp_an(0));
            chk("model_dp_a",   {3'b0, dp_a},   {3'b0, exp_dp(0)});
            chk("model_tick_a", {3'b0, tick_a}, {3'b0, m_tick[0]});
            chk("model_sel_b",  {2'b0, sel_b},  4'(m_sel[1]));
            chk("model_an_b",   an_b,           exp_an(1));
            chk("model_dp_b",   {3'b0, dp_b},   {3'b0, exp_dp(1)});
            chk("model_tick_b", {3'b0, tick_b}, {3'b0, m_tick[1]});
        end
    end

    typedef struct {
        logic [3:0] mask;
        logic [3:0] dp;
        logic [1:0] sel;
        logic [3:0] an;
        logic       dpn;
        logic       tick;
    } slot_t;

    slot_t tbl[12];

    task automatic wait_digit(input logic [1:0] s, input logic [3:0] an, input string nm);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 80 && !hit; i++) begin
            @(posedge clk); #1;
            hit = (sel_a == s) && (an_a == an);
        end
        if (!hit) chk(nm, 4'h0, 4'h1);
    endtask

    initial begin
        tbl[0]  = '{4'h0, 4'h0, 2'd0, 4'b1110, 1'b1, 1'b0};
        tbl[1]  = '{4'h0, 4'h0, 2'd1, 4'b1101, 1'b1, 1'b0};
        tbl[2]  = '{4'h0, 4'h0, 2'd2, 4'b1011, 1'b1, 1'b0};
        tbl[3]  = '{4'h0, 4'h0, 2'd3, 4'b0111, 1'b1, 1'b0};
        tbl[4]  = '{4'hC, 4'h4, 2'd0, 4'b1110, 1'b1, 1'b1};
        tbl[5]  = '{4'hC, 4'h4, 2'd1, 4'b1101, 1'b1, 1'b0};
        tbl[6]  = '{4'hC, 4'h4, 2'd2, 4'b1111, 1'b1, 1'b0};
        tbl[7]  = '{4'hC, 4'h4, 2'd3, 4'b1111, 1'b1, 1'b0};
        tbl[8]  = '{4'h0, 4'h4, 2'd0, 4'b1110, 1'b1, 1'b1};
        tbl[9]  = '{4'h0, 4'h4, 2'd1, 4'b1101, 1'b1, 1'b0};
        tbl[10] = '{4'h0, 4'h4, 2'd2, 4'b1011, 1'b0, 1'b0};
        tbl[11] = '{4'h0, 4'h4, 2'd3, 4'b0111, 1'b1, 1'b0};

        #1 reset = 1'b1;
        #2;
        chk("rst_an",   an_a, 4'hF);
        chk("rst_dp",   {3'b0, dp_a}, 4'h1);
        chk("rst_sel",  {2'b0, sel_a}, 4'h0);
        chk("rst_tick", {3'b0, tick_a}, 4'h0);
        mon_on = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // Slot table: 2 blank cycles then 6 show cycles per slot, three frames.
        for (int i = 0; i < 12; i++) begin
            en = 1'b1;
            blank_mask = tbl[i].mask;
            dp_pos = tbl[i].dp;
            for (int c = 0; c < DIV_A; c++) begin
                @(posedge clk); #1;
                chk($sformatf("tbl%0d_sel", i), {2'b0, sel_a}, {2'b0, tbl[i].sel});
                chk($sformatf("tbl%0d_an", i), an_a, (c < DEAD_A) ? 4'hF : tbl[i].an);
                chk($sformatf("tbl%0d_dp", i), {3'b0, dp_a},
                    {3'b0, (c < DEAD_A) ? 1'b1 : tbl[i].dpn});
                chk($sformatf("tbl%0d_tick", i), {3'b0, tick_a},
                    {3'b0, (c == 0) ? tbl[i].tick : 1'b0});
            end
        end

        // Drop enable mid-SHOW on digit 2, then re-enable.
        blank_mask = 4'h0; dp_pos = 4'h0;
        wait_digit(2'd2, 4'b1011, "wait_sel2");
        en = 1'b0;
        @(posedge clk); #1;
        chk("en_off_an", an_a, 4'hF);
        chk("en_off_sel", {2'b0, sel_a}, 4'h2);
        repeat (3) @(posedge clk);
        #1 en = 1'b1;
        @(posedge clk); #1;
        chk("reen_blank0", an_a, 4'hF);
        @(posedge clk); #1;
        chk("reen_blank1", an_a, 4'hF);
        @(posedge clk); #1;
        chk("reen_show", an_a, 4'b1011);
        chk("reen_sel", {2'b0, sel_a}, 4'h2);

        // Asynchronous reset in the middle of a digit-3 SHOW cycle.
        wait_digit(2'd3, 4'b0111, "wait_sel3");
        #2 reset = 1'b1;
        #1;
        chk("async_rst_an", an_a, 4'hF);
        chk("async_rst_sel", {2'b0, sel_a}, 4'h0);
        chk("async_rst_tick", {3'b0, tick_a}, 4'h0);
        chk("async_rst_dp", {3'b0, dp_a}, 4'h1);
        @(posedge clk); #1 reset = 1'b0;

        // No-dead-time instance: new digit every 2 cycles, tick every 8.
        for (int k = 0; k < 32; k++) begin
            @(posedge clk); #1;
            chk($sformatf("dead0_an%0d", k), an_b, ~oh4(k / 2));
            chk($sformatf("dead0_tick%0d", k), {3'b0, tick_b},
                {3'b0, (k > 0 && k % 8 == 0)});
        end

        // Random stimulus, checked by the model on every falling edge.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            reset = ($urandom_range(0, 199) == 0);
            en = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 7) == 0) blank_mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0)
                dp_pos = ($urandom_range(0, 4) == 4) ? 4'h0 : oh4(int'($urandom_range(0, 3)));
        end
        reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
